// File: rtl/bus_transfer_arbiter.sv
// Round-robin scheduler for register-to-register moves on the shared data bus.
// Optional feature macro BUS_ARB_COUNT_EN adds INC / BUS_COUNT post-increment support.
module bus_transfer_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic [NUM_REQ-1:0]       REQ,
    input  logic [NUM_REQ*SEL_W-1:0] SRC,
    input  logic [NUM_REQ*SEL_W-1:0] DST,
`ifdef BUS_ARB_COUNT_EN
    input  logic [NUM_REQ-1:0]       INC,
    output logic [NUM_REGS-1:0]      BUS_COUNT,
`endif
    output logic [NUM_REQ-1:0]       GRANT,
    output logic [NUM_REGS-1:0]      BUS_ENABLE,
    output logic [NUM_REGS-1:0]      BUS_LOAD,
    output logic                     BUSY,
    output logic                     ERR,
    output logic [1:0]               dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Handshake: a requester holds REQ/SRC/DST stable until it sees its GRANT
    // pulse and drops REQ the cycle after; fields are captured at arbitration,
    // so later changes never disturb the transfer in flight.

    state_t               state, state_n;
    logic [IDX_W-1:0]     ptr, ptr_n;
    logic [IDX_W-1:0]     win_q, win_n;
    logic [IDX_W-1:0]     arb_idx, cand;
    logic [SEL_W-1:0]     src_q, src_n, dst_q, dst_n;
    logic                 arb_valid, capture, legal_n;
    logic [NUM_REQ-1:0]   req_masked;
    logic [SEL_W-1:0]     src_arr [NUM_REQ];
    logic [SEL_W-1:0]     dst_arr [NUM_REQ];

    logic [NUM_REQ-1:0]   grant_n;
    logic [NUM_REGS-1:0]  enable_n, load_n;
    logic                 busy_n, err_n;
`ifdef BUS_ARB_COUNT_EN
    logic                 inc_q, inc_n;
    logic [NUM_REGS-1:0]  count_n;
`endif

    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        if (int'(sel) < NUM_REGS) oh[sel] = 1'b1;
        return oh;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign src_arr[g] = SRC[g*SEL_W +: SEL_W];
        assign dst_arr[g] = DST[g*SEL_W +: SEL_W];
    end

    // The requester just granted is excluded from the LATCH-cycle re-arbitration.
    always_comb begin
        req_masked = REQ;
        if (state == LATCH) req_masked[win_q] = 1'b0;
        arb_valid = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!arb_valid && req_masked[cand]) begin
                arb_valid = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign capture = arb_valid && ((state == IDLE) || (state == LATCH));

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (arb_valid) state_n = DRIVE;
            DRIVE:   state_n = LATCH;
            LATCH:   state_n = arb_valid ? DRIVE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        win_n   = capture ? arb_idx : win_q;
        src_n   = capture ? src_arr[arb_idx] : src_q;
        dst_n   = capture ? dst_arr[arb_idx] : dst_q;
        ptr_n   = capture ? IDX_W'((int'(arb_idx) + 1) % NUM_REQ) : ptr;
        legal_n = (src_n != dst_n) && (int'(src_n) < NUM_REGS) && (int'(dst_n) < NUM_REGS);
`ifdef BUS_ARB_COUNT_EN
        inc_n   = capture ? INC[arb_idx] : inc_q;
`endif
    end

    // Output comb computes the values for the coming cycle so every output is a flop.
    always_comb begin
        grant_n  = '0;
        enable_n = '0;
        load_n   = '0;
        err_n    = 1'b0;
        busy_n   = (state_n != IDLE);
`ifdef BUS_ARB_COUNT_EN
        count_n  = '0;
`endif
        case (state_n)
            DRIVE: begin
                if (legal_n) enable_n = sel_onehot(src_n);
            end
            LATCH: begin
                grant_n[win_n] = 1'b1;
                err_n          = !legal_n;
                if (legal_n) begin
                    enable_n = sel_onehot(src_n);
                    load_n   = sel_onehot(dst_n);
`ifdef BUS_ARB_COUNT_EN
                    if (inc_n) count_n = sel_onehot(src_n);
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            ptr        <= '0;
            win_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            GRANT      <= '0;
            BUS_ENABLE <= '0;
            BUS_LOAD   <= '0;
            BUSY       <= 1'b0;
            ERR        <= 1'b0;
`ifdef BUS_ARB_COUNT_EN
            inc_q      <= 1'b0;
            BUS_COUNT  <= '0;
`endif
        end else begin
            ptr        <= ptr_n;
            win_q      <= win_n;
            src_q      <= src_n;
            dst_q      <= dst_n;
            GRANT      <= grant_n;
            BUS_ENABLE <= enable_n;
            BUS_LOAD   <= load_n;
            BUSY       <= busy_n;
            ERR        <= err_n;
`ifdef BUS_ARB_COUNT_EN
            inc_q      <= inc_n;
            BUS_COUNT  <= count_n;
`endif
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Directed bench for bus_transfer_arbiter: transaction-queue model plus literal checks.
// Build with BUS_ARB_COUNT_EN defined to also exercise the post-increment path.
module tb_bus_transfer_arbiter;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  REQ = '0;
    logic [11:0] SRC = '0;
    logic [11:0] DST = '0;
`ifdef BUS_ARB_COUNT_EN
    logic [3:0]  INC = '0;
    logic [7:0]  BUS_COUNT;
`endif
    logic [3:0]  GRANT;
    logic [7:0]  BUS_ENABLE, BUS_LOAD;
    logic        BUSY, ERR;
    logic [1:0]  dbg_state;

    bus_transfer_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .SEL_W(3)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .REQ(REQ), .SRC(SRC), .DST(DST),
`ifdef BUS_ARB_COUNT_EN
        .INC(INC), .BUS_COUNT(BUS_COUNT),
`endif
        .GRANT(GRANT), .BUS_ENABLE(BUS_ENABLE), .BUS_LOAD(BUS_LOAD),
        .BUSY(BUSY), .ERR(ERR), .dbg_state(dbg_state)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [7:0] en;
        logic [7:0] ld;
        logic [7:0] cnt;
        logic [3:0] gr;
        logic       err;
        logic       busy;
    } rec_t;

    rec_t cur;
    rec_t exp_q[$];
    int   mptr = 0;
    int   grant_log[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   auto_drop = 1'b0;

    function automatic rec_t idle_rec();
        rec_t r;
        r.en = '0; r.ld = '0; r.cnt = '0; r.gr = '0; r.err = 1'b0; r.busy = 1'b0;
        return r;
    endfunction

    task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A slot is two cycles of expected outputs; a new slot may be scheduled only
    // when no further expected cycles are pending (idle, or the final LATCH cycle).
    task automatic model_step();
        logic [3:0] cand;
        int w, s, d, inc;
        bit legal;
        rec_t rd, rl;
        if (!RESET) begin
            cur = idle_rec();
            exp_q.delete();
            mptr = 0;
            return;
        end
        if (exp_q.size() == 0) begin
            cand = REQ & ~cur.gr;
            w = -1;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (mptr + k) % 4;
                if (w < 0 && ((cand >> c) & 4'h1) != 4'h0) w = c;
            end
            if (w >= 0) begin
                s = int'((SRC >> (3 * w)) & 12'h7);
                d = int'((DST >> (3 * w)) & 12'h7);
                inc = 0;
`ifdef BUS_ARB_COUNT_EN
                inc = int'((INC >> w) & 4'h1);
`endif
                legal = (s != d);
                rd = idle_rec();
                rd.busy = 1'b1;
                rd.en = legal ? 8'(1 << s) : 8'h00;
                rl = rd;
                rl.ld = legal ? 8'(1 << d) : 8'h00;
                rl.gr = 4'(1 << w);
                rl.err = !legal;
                rl.cnt = (legal && inc != 0) ? 8'(1 << s) : 8'h00;
                exp_q.push_back(rd);
                exp_q.push_back(rl);
                mptr = (w + 1) % 4;
            end
        end
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : idle_rec();
    endtask

    initial begin
        cur = idle_rec();
        forever begin
            @(posedge CLOCK or negedge RESET);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge CLOCK);
            check_v("bus_enable", 32'(BUS_ENABLE), 32'(cur.en));
            check_v("bus_load", 32'(BUS_LOAD), 32'(cur.ld));
            check_v("grant", 32'(GRANT), 32'(cur.gr));
            check_v("err", 32'(ERR), 32'(cur.err));
            check_v("busy", 32'(BUSY), 32'(cur.busy));
`ifdef BUS_ARB_COUNT_EN
            check_v("bus_count", 32'(BUS_COUNT), 32'(cur.cnt));
`endif
            check_v("enable_onehot0", 32'($onehot0(BUS_ENABLE)), 32'd1);
            check_v("load_onehot0", 32'($onehot0(BUS_LOAD)), 32'd1);
            check_v("grant_onehot0", 32'($onehot0(GRANT)), 32'd1);
            for (int i = 0; i < 4; i++)
                if (((GRANT >> i) & 4'h1) != 4'h0) grant_log.push_back(i);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge CLOCK);
        #1;
        if (auto_drop) REQ = REQ & ~GRANT;
    endtask

    task automatic set_req(input int i, input int s, input int d);
        SRC = (SRC & ~(12'h7 << (3 * i))) | (12'(s & 7) << (3 * i));
        DST = (DST & ~(12'h7 << (3 * i))) | (12'(d & 7) << (3 * i));
    endtask

    initial begin
        int exp_rr[4];
        int exp_ct[4];
        exp_rr = '{0, 1, 2, 3};
        exp_ct = '{3, 1, 3, 1};
        #1 RESET = 1'b0;
        repeat (3) tick();
        RESET = 1'b1;
        tick();

        // reset asserted in the middle of a DRIVE cycle
        auto_drop = 1'b1;
        grant_log.delete();
        set_req(0, 2, 5);
        REQ = 4'b0001;
        tick();
        check_v("rst_pre_enable", 32'(BUS_ENABLE), 32'h04);
        #1 RESET = 1'b0;
        #1;
        check_v("rst_enable", 32'(BUS_ENABLE), 32'h00);
        check_v("rst_load", 32'(BUS_LOAD), 32'h00);
        check_v("rst_grant", 32'(GRANT), 32'h0);
        check_v("rst_busy", 32'(BUSY), 32'h0);
        check_v("rst_state", 32'(dbg_state), 32'h0);
        REQ = 4'b0000;
        tick();
        tick();
        RESET = 1'b1;
        tick();
        tick();
        check_v("post_rst_busy", 32'(BUSY), 32'h0);
        check_v("post_rst_state", 32'(dbg_state), 32'h0);
        check_v("post_rst_no_grant", 32'(grant_log.size()), 32'd0);

        // round robin from pointer 0 with all four requesting
        grant_log.delete();
        for (int i = 0; i < 4; i++) set_req(i, i, i + 4);
        REQ = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_v("rr_busy", 32'(BUSY), 32'h1);
        end
        tick();
        check_v("rr_busy_end", 32'(BUSY), 32'h0);
        check_v("rr_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check_v("rr_order", 32'(grant_log[i]), 32'(exp_rr[i]));

        // single move: requester 0, reg2 -> reg5
        set_req(0, 2, 5);
        REQ = 4'b0001;
        tick();
        check_v("mv_drive_enable", 32'(BUS_ENABLE), 32'h04);
        check_v("mv_drive_load", 32'(BUS_LOAD), 32'h00);
        check_v("mv_drive_grant", 32'(GRANT), 32'h0);
        tick();
        check_v("mv_latch_enable", 32'(BUS_ENABLE), 32'h04);
        check_v("mv_latch_load", 32'(BUS_LOAD), 32'h20);
        check_v("mv_latch_grant", 32'(GRANT), 32'h1);
        tick();
        check_v("mv_done_enable", 32'(BUS_ENABLE), 32'h00);
        check_v("mv_done_load", 32'(BUS_LOAD), 32'h00);
        check_v("mv_done_grant", 32'(GRANT), 32'h0);

        // requester 1 move leaves the pointer at 2
        set_req(1, 6, 7);
        REQ = 4'b0010;
        repeat (4) tick();

        // contention between requesters 1 and 3, both held
        auto_drop = 1'b0;
        grant_log.delete();
        set_req(1, 1, 2);
        set_req(3, 5, 0);
        REQ = 4'b1010;
        repeat (8) tick();
        REQ = 4'b0000;
        repeat (4) tick();
        check_v("ct_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check_v("ct_order", 32'(grant_log[i]), 32'(exp_ct[i]));

        // illegal request: SRC == DST
        auto_drop = 1'b1;
        set_req(0, 3, 3);
        REQ = 4'b0001;
        tick();
        check_v("ill_drive_enable", 32'(BUS_ENABLE), 32'h00);
        check_v("ill_drive_busy", 32'(BUSY), 32'h1);
        tick();
        check_v("ill_grant", 32'(GRANT), 32'h1);
        check_v("ill_err", 32'(ERR), 32'h1);
        check_v("ill_enable", 32'(BUS_ENABLE), 32'h00);
        check_v("ill_load", 32'(BUS_LOAD), 32'h00);
        tick();
        check_v("ill_done_err", 32'(ERR), 32'h0);

`ifdef BUS_ARB_COUNT_EN
        // post-increment move: reg1 -> reg4, reg1 counted
        set_req(2, 1, 4);
        INC = 4'b0100;
        REQ = 4'b0100;
        tick();
        check_v("cnt_drive_enable", 32'(BUS_ENABLE), 32'h02);
        check_v("cnt_drive_count", 32'(BUS_COUNT), 32'h00);
        tick();
        check_v("cnt_latch_count", 32'(BUS_COUNT), 32'h02);
        check_v("cnt_latch_load", 32'(BUS_LOAD), 32'h10);
        tick();
        check_v("cnt_done_count", 32'(BUS_COUNT), 32'h00);
        INC = 4'b0000;
`endif

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
